// File: rtl/ahb_bram_if_if.sv
// AHB-Lite slave bus plus block-RAM bank signals for ahb_bram_if.
interface ahb_bram_if_if #(
  parameter int unsigned AW = 16
);
  // AHB-Lite bus
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  // Memory bank
  logic [AW-3:0] BRAM_ADDR;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WREN;
  logic [31:0]   BRAM_RDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA, BRAM_RDATA,
    output HREADYOUT, HRDATA, HRESP, BRAM_ADDR, BRAM_WDATA, BRAM_WREN
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA, BRAM_RDATA,
    input  HREADYOUT, HRDATA, HRESP, BRAM_ADDR, BRAM_WDATA, BRAM_WREN
  );
endinterface

// File: rtl/ahb_bram_if.sv
// AHB-Lite slave bridging to a single-port synchronous block RAM.
// Reads are zero-wait; a write data phase that collides with a read
// address phase costs one wait state. Illegal sizes/alignments get a
// two-cycle ERROR response without touching the bank.
module ahb_bram_if #(
  parameter int unsigned AW = 16
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_bram_if_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WSTALL, ERR1, ERR2} state_t;

  state_t        state_q, state_d;
  logic          wr_pend_q, wr_pend_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-3:0] addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;

  logic          valid;
  logic          illegal;
  logic          conflict;
  logic          accept;
  logic [3:0]    lane_mask;
  logic          unused_bits;

  // Address-phase decode: transfer qualification, legality and lane mask.
  always_comb begin
    valid   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    illegal = (bus.HSIZE > 3'd2)
            | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
            | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
    case (bus.HSIZE)
      3'd0:    lane_mask = 4'b0001 << bus.HADDR[1:0];
      3'd1:    lane_mask = 4'b0011 << bus.HADDR[1:0];
      default: lane_mask = 4'b1111;
    endcase
    // HREADY normally mirrors our own HREADYOUT, so the collision test
    // must not depend on it or it would form a combinational loop.
    conflict    = wr_pend_q & bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE & ~illegal;
    accept      = valid & ~conflict & (state_q != ERR1);
    unused_bits = ^{bus.HADDR[31:AW], bus.HTRANS[0]};
  end

  // Next-state, pending data-phase bookkeeping and bus/bank outputs.
  always_comb begin
    state_d        = state_q;
    wr_pend_d      = accept & ~illegal & bus.HWRITE;
    rd_pend_d      = accept & ~illegal & ~bus.HWRITE;
    addr_d         = accept ? bus.HADDR[AW-1:2] : addr_q;
    mask_d         = accept ? lane_mask : mask_q;
    bus.HREADYOUT  = 1'b1;
    bus.HRESP      = 1'b0;
    bus.HRDATA     = rd_pend_q ? bus.BRAM_RDATA : '0;
    bus.BRAM_ADDR  = wr_pend_q ? addr_q : bus.HADDR[AW-1:2];
    bus.BRAM_WDATA = bus.HWDATA;
    bus.BRAM_WREN  = wr_pend_q ? mask_q : '0;
    case (state_q)
      IDLE: begin
        if (conflict) begin
          bus.HREADYOUT = 1'b0;
          state_d       = WSTALL;
        end else if (accept && illegal) begin
          state_d = ERR1;
        end else begin
          state_d = IDLE;
        end
      end
      WSTALL, ERR2: begin
        bus.HRESP = (state_q == ERR2);
        state_d   = (accept && illegal) ? ERR1 : IDLE;
      end
      ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
        state_d       = ERR2;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered address-phase information.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
    end
  end

endmodule

// File: doc/ahb_bram_if.md
AHB_BRAM_IF -- requirements
Module: ahb_bram_if

Parameters
REQ-001 AW, default 16, byte-address width of the attached memory bank; bank size is 2^AW bytes.

Interface
REQ-002 HCLK  input  1  system clock; all state changes on the rising edge.
REQ-003 HRESETn  input  1  asynchronous, active-low reset.
REQ-004 HSEL  input  1  slave select.
REQ-005 HADDR  input  32  byte address; only [AW-1:0] is decoded.
REQ-006 HTRANS  input  2  transfer type; NONSEQ (2'b10) and SEQ (2'b11) are valid.
REQ-007 HSIZE  input  3  transfer size: 0 = byte, 1 = half, 2 = word.
REQ-008 HWRITE  input  1  1 = write, 0 = read.
REQ-009 HREADY  input  1  bus-level ready; an address phase is accepted when this is 1.
REQ-010 HWDATA  input  32  write data, valid in the data phase.
REQ-011 HREADYOUT  output  1  slave ready.
REQ-012 HRDATA  output  32  read data.
REQ-013 HRESP  output  1  0 = OKAY, 1 = ERROR.
REQ-014 BRAM_ADDR  output  AW-2  word address to the bank, bits [AW-1:2].
REQ-015 BRAM_WDATA  output  32  write data to the bank.
REQ-016 BRAM_WREN  output  4  per-byte-lane write enable to the bank.
REQ-017 BRAM_RDATA  input  32  bank read data; valid one HCLK after BRAM_ADDR is presented.

Function
REQ-018 A valid transfer is defined as HSEL & HREADY & HTRANS[1]; an address phase is registered only on a valid transfer.
REQ-019 Lane mask for HSIZE/HADDR[1:0]:
- byte: 4'b0001 << HADDR[1:0].
- half: 4'b0011 << HADDR[1:0].
- word: 4'b1111.
REQ-020 A transfer is illegal when HSIZE>2, when a half transfer has HADDR[0]=1, or when a word transfer has HADDR[1:0]!=0.
REQ-021 FSM states are IDLE, WSTALL, ERR1 and ERR2; the reset state is IDLE.
REQ-022 Read, zero-wait path: in the read address phase, BRAM_ADDR = HADDR[AW-1:2] combinationally; in the data phase HRDATA = BRAM_RDATA and HREADYOUT = 1.
REQ-023 Write data phase: in the first data-phase cycle, BRAM_ADDR = registered write address, BRAM_WDATA = HWDATA, and BRAM_WREN = registered lane mask.
REQ-024 BRAM_WREN is nonzero for exactly one cycle per legal write.
REQ-025 Write followed by a write or by no transfer: HREADYOUT = 1; the write completes in one data-phase cycle.
REQ-026 Write whose data phase coincides with a valid read address phase (address conflict):
- HREADYOUT = 0 for one cycle and the FSM enters WSTALL.
- The write is issued in that cycle.
- In WSTALL, BRAM_ADDR = HADDR (held stable by the master), HREADYOUT = 1, BRAM_WREN = 0, then the FSM returns to IDLE.
- Read data in the following data phase reflects the just-written bytes.
REQ-027 Illegal transfer: the bank is not accessed (BRAM_WREN = 0).
- ERR1: HREADYOUT = 0, HRESP = 1.
- ERR2: HREADYOUT = 1, HRESP = 1.
- Then IDLE.
REQ-028 When no data phase is pending, HRDATA = 32'h0, HRESP = 0 and HREADYOUT = 1.
REQ-029 BRAM_ADDR wraps modulo 2^(AW-2) words; HADDR bits at and above AW are ignored.
REQ-030 An IDLE or BUSY HTRANS, or HSEL = 0, leaves the FSM in IDLE with no bank access.

Reset
REQ-031 While HRESETn = 0, the following hold immediately (asynchronously) and stay until the first HCLK edge after release:
- FSM = IDLE, registered address = 0, pending-write flag = 0.
- HREADYOUT = 1, HRESP = 0, BRAM_WREN = 0.
REQ-032 Reset asserted mid-transfer (WSTALL or ERR1) aborts the transfer; no BRAM write may occur in or after the reset cycle.

Verification
REQ-033 Word write 0xDEADBEEF at 0x10, then read at 0x10 -> BRAM_WREN = 4'hF for one cycle, BRAM_ADDR = 4, HRDATA = 0xDEADBEEF, no wait states.
REQ-034 Byte write 0xAA at 0x13, then half write 0x1234 at 0x10, then word read at 0x10 -> WREN 4'h8 then 4'h3, HRDATA = 0xAA??1234 with the untouched byte preserved.
REQ-035 Write 0x55 to 0x20 back-to-back with a read of 0x20 -> exactly one HREADYOUT-low cycle (WSTALL), read returns 0x55 in byte 0.
REQ-036 Half transfer at 0x01 and an HSIZE = 3 transfer -> ERR1/ERR2 sequence (HREADYOUT 0 then 1, HRESP = 1 for both cycles), BRAM_WREN stays 0.
REQ-037 Assert HRESETn = 0 during WSTALL -> HREADYOUT = 1 and BRAM_WREN = 0 without waiting for a clock; after release, a read of 0x0 completes with zero waits.
REQ-038 HADDR = 0x0001_0004 with AW = 16 -> BRAM_ADDR = 1 (upper address bits ignored).
